// File: rtl/mul_pkg.sv
// Shared types for the RV32M multiply controller: op encoding, FSM states, datapath width.
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Signed-to-magnitude conversion of both operands and conditional two's-complement of the product.
module mul_sign_fix #(
  parameter int W = mul_pkg::XLEN
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           a_signed_i,
  input  logic           b_signed_i,
  output logic [W-1:0]   mag_a_o,
  output logic [W-1:0]   mag_b_o,
  output logic           neg_o,
  input  logic [2*W-1:0] prod_i,
  input  logic           prod_neg_i,
  output logic [2*W-1:0] result_o
);

  logic a_neg;
  logic b_neg;

  assign a_neg = a_signed_i & a_i[W-1];
  assign b_neg = b_signed_i & b_i[W-1];

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign mag_a_o = a_neg ? (~a_i + 1'b1) : a_i;
  assign mag_b_o = b_neg ? (~b_i + 1'b1) : b_i;
  assign neg_o   = a_neg ^ b_neg;

  // Negating zero wraps back to zero, so no -0 result can appear.
  assign result_o = prod_neg_i ? (~prod_i + 1'b1) : prod_i;

endmodule

// File: rtl/mul_unit.sv
// Combinational W x W -> 2W unsigned multiplier; the controller treats it as a multicycle path.
module mul_unit #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] out
);

  assign out = a * b;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multicycle RV32M multiply controller in front of mul_unit.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips CALC and completes on the accept edge.
module mul_issue_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  import mul_pkg::*;

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic              neg_q;
  logic              sel_hi_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  mul_op_e           op;
  logic              a_signed;
  logic              b_signed;
  logic [XLEN-1:0]   mag_a_d;
  logic [XLEN-1:0]   mag_b_d;
  logic              neg_d;
  logic              accept_d;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   result_d;

  assign op       = mul_op_e'(i_funct3);
  assign a_signed = (op == MULH) || (op == MULHSU);
  assign b_signed = (op == MULH);
  // Reserved encodings (funct3[2]=1) are never accepted.
  assign accept_d = i_valid && !i_flush && !i_funct3[2];

  mul_sign_fix #(.W(XLEN)) u_sign_fix (
    .a_i        (i_a),
    .b_i        (i_b),
    .a_signed_i (a_signed),
    .b_signed_i (b_signed),
    .mag_a_o    (mag_a_d),
    .mag_b_o    (mag_b_d),
    .neg_o      (neg_d),
    .prod_i     (prod),
    .prod_neg_i (neg_q),
    .result_o   (prod_fixed)
  );

  mul_unit #(.W(XLEN)) u_mul_unit (
    .a   (mag_a_q),
    .b   (mag_b_q),
    .out (prod)
  );

  assign result_d = sel_hi_q ? prod_fixed[2*XLEN-1:XLEN] : prod_fixed[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            sel_hi_q <= (op != MUL);
            cnt_q    <= CNT_INIT;
`ifdef MUL_ZERO_BYPASS_EN
            if (i_a == '0 || i_b == '0) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= '0;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          if (i_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            // Operands have been stable for the full multicycle budget.
            result_q <= result_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Flush takes priority over a simultaneous consume.
          if (i_flush) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
          end else if (i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q != IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl: expected words queued at issue, popped when o_valid rises.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  mul_issue_ctrl #(.MUL_CYCLES(MC), .XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_funct3 (i_funct3),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  // Reference: sign/zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_valid  = 1'b1;
    i_funct3 = f;
    i_a      = a;
    i_b      = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output logic [31:0] res, output bit to);
    lat = 0;
    to  = 1'b0;
    while (o_valid !== 1'b1 && lat <= 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (o_valid !== 1'b1) to = 1'b1;
    res = o_result;
  endtask

  task automatic consume();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_result !== 32'h0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b result=%h busy=%b ready=%b want 0 0 0 1",
               o_valid, o_result, o_busy, o_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b busy=%b want 1 0", o_ready, o_busy);
    end
  endtask

  // Runs a table of ops; expected words come from the table or the model.
  task automatic test_table(input string name, input int n, input logic [2:0] fs[8],
                            input logic [31:0] as[8], input logic [31:0] bs[8],
                            input logic [31:0] es[8], input bit use_model);
    int lat;
    logic [31:0] r, e;
    bit to;
    for (int i = 0; i < n; i++) begin
      issue(fs[i], as[i], bs[i]);
      sb.push_back(use_model ? model(fs[i], as[i], bs[i]) : es[i]);
      collect(lat, r, to);
      e = sb.pop_front();
      $display("txn %s f3=%0d a=%h b=%h result=%h lat=%0d", name, fs[i], as[i], bs[i], r, lat);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL %s_timeout[%0d] o_valid never rose within 20 cycles", name, i);
      end else begin
        checks++;
        if (r !== e) begin
          failures++;
          $display("FAIL %s_result[%0d] got %h want %h", name, i, r, e);
        end
        checks++;
        if (lat != MC) begin
          failures++;
          $display("FAIL %s_latency[%0d] got %0d want %0d", name, i, lat, MC);
        end
      end
      consume();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_release[%0d] got valid=%b ready=%b busy=%b want 0 1 0",
                 name, i, o_valid, o_ready, o_busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [2:0]  fs[8] = '{3'b000, 3'b011, 3'b001, 3'b000, 3'b011, 3'b001, 3'b001, 3'b010};
    logic [31:0] as[8] = '{32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[8] = '{32'h87654321, 32'h87654321, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] es[8] = '{32'h70B88D78, 32'h09A0CD05, 32'h00000000, 32'h00000001,
                           32'hFFFFFFFE, 32'h40000000, 32'h3FFFFFFF, 32'hFFFFFFFF};
    test_table("basic", 8, fs, as, bs, es, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  fs[8];
    logic [31:0] as[8], bs[8], es[8];
    for (int i = 0; i < 8; i++) begin
      fs[i] = 3'($urandom_range(0, 3));
      as[i] = $urandom | 32'h1;
      bs[i] = $urandom | 32'h100;
      es[i] = '0;
    end
    test_table("random", 8, fs, as, bs, es, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] r, e;
    bit to;
    int bad = 0;
    issue(3'b000, 32'd3, 32'd5);
    sb.push_back(32'd15);
    collect(lat, r, to);
    e = sb.pop_front();
    $display("txn backpressure f3=0 a=3 b=5 result=%h lat=%0d", r, lat);
    checks++;
    if (to || r !== e) begin
      failures++;
      $display("FAIL bp_result got %h timeout=%0d want %h", r, to, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_funct3 = 3'b011;
      i_a = 32'hFFFFFFFF;
      i_b = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      if (o_valid !== 1'b1 || o_result !== e || o_ready !== 1'b0) bad++;
    end
    i_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable cycles want 0 (last valid=%b result=%h ready=%b)",
               bad, o_valid, o_result, o_ready);
    end
    consume();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got valid=%b ready=%b busy=%b want 0 1 0", o_valid, o_ready, o_busy);
    end
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_ignored_request got %0d busy/valid cycles want 0", bad);
    end
  endtask

  task automatic test_flush();
    int lat, bad;
    logic [31:0] r, e;
    bit to;
    issue(3'b000, 32'd7, 32'd9);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    $display("txn flush_calc f3=0 a=7 b=9 busy=%b valid=%b", o_busy, o_valid);
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc got busy=%b ready=%b valid=%b want 0 1 0", o_busy, o_ready, o_valid);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL flush_no_valid got %0d valid cycles want 0", bad);
    end
    @(negedge clk);
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_funct3 = 3'b000;
    i_a = 32'd2;
    i_b = 32'd2;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    $display("txn flush_idle f3=0 a=2 b=2 busy=%b", o_busy);
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle_block got busy=%b ready=%b want 0 1", o_busy, o_ready);
    end
    issue(3'b011, 32'h00010000, 32'h00010000);
    sb.push_back(32'h00000001);
    collect(lat, r, to);
    e = sb.pop_front();
    $display("txn flush_done f3=3 a=00010000 b=00010000 result=%h lat=%0d", r, lat);
    checks++;
    if (to || r !== e) begin
      failures++;
      $display("FAIL flush_done_result got %h timeout=%0d want %h", r, to, e);
    end
    @(negedge clk);
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_done got valid=%b ready=%b busy=%b want 0 1 0", o_valid, o_ready, o_busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic busy_before;
    issue(3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF);
    #3;
    busy_before = o_busy;
    rst_n = 1'b0;
    #1;
    $display("txn reset_mid_calc f3=1 busy_before=%b valid=%b result=%h", busy_before, o_valid, o_result);
    checks++;
    if (busy_before !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy_before got %b want 1", busy_before);
    end
    checks++;
    if (o_valid !== 1'b0 || o_result !== 32'h0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_outputs got valid=%b result=%h busy=%b ready=%b want 0 0 0 1",
               o_valid, o_result, o_busy, o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    int lat, exp_lat;
    logic [31:0] r, e;
    bit to;
`ifdef MUL_ZERO_BYPASS_EN
    exp_lat = 0;
`else
    exp_lat = MC;
`endif
    issue(3'b000, 32'h0, 32'hDEADBEEF);
    sb.push_back(32'h0);
    collect(lat, r, to);
    e = sb.pop_front();
    $display("txn zero f3=0 a=00000000 b=deadbeef result=%h lat=%0d", r, lat);
    checks++;
    if (to || r !== e) begin
      failures++;
      $display("FAIL zero_result got %h timeout=%0d want %h", r, to, e);
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL zero_latency got %0d want %0d", lat, exp_lat);
    end
    consume();
  endtask

  task automatic test_reserved();
    @(negedge clk);
    i_valid = 1'b1;
    i_funct3 = 3'b101;
    i_a = 32'd3;
    i_b = 32'd4;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    $display("txn reserved f3=5 a=3 b=4 busy=%b ready=%b", o_busy, o_ready);
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reserved_ignored got busy=%b ready=%b valid=%b want 0 1 0", o_busy, o_ready, o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_calc();
    test_zero();
    test_reserved();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
